// File: rtl/key_conditioner.sv
// Push-button conditioner: 2-flop synchronizer, debounce FSM, press/release strobes
// and auto-repeat strobes while the key stays held.
module key_conditioner #(
    parameter int unsigned STABLE_CYCLES  = 1000000,
    parameter bit          KEY_ACTIVE_LOW = 1'b1,
    parameter bit          REPEAT_EN      = 1'b1,
    parameter int unsigned REPEAT_DELAY   = 25000000,
    parameter int unsigned REPEAT_PERIOD  = 5000000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic key_i,
    output logic pressed_o,
    output logic press_pulse_o,
    output logic release_pulse_o,
    output logic repeat_pulse_o
);

    localparam int unsigned CW   = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
    localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned RW   = $clog2(RMAX + 1);

    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [RW-1:0] R_DELAY  = RW'(REPEAT_DELAY);
    localparam logic [RW-1:0] R_PERIOD = RW'(REPEAT_PERIOD);
    localparam logic          IDLE_LVL = KEY_ACTIVE_LOW;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRESS_WAIT,
        S_PRESSED,
        S_RELEASE_WAIT
    } state_t;

    logic          sync1_q, sync2_q;
    logic          act;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [RW-1:0] rcnt_q, rcnt_d, rcnt_inc;
    logic          rdone_q, rdone_d;
    logic          pressed_q, pressed_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic          repeat_q, repeat_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q <= IDLE_LVL;
            sync2_q <= IDLE_LVL;
        end else begin
            sync1_q <= key_i;
            sync2_q <= sync1_q;
        end
    end

    assign act      = sync2_q ^ KEY_ACTIVE_LOW;
    assign rcnt_inc = rcnt_q + RW'(1);

    // rdone_q selects the repeat target: REPEAT_DELAY until the first pulse, then
    // REPEAT_PERIOD; the counter restarts at every pulse so it never wraps.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rcnt_d    = rcnt_q;
        rdone_d   = rdone_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        repeat_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (act) begin
                    state_d = S_PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            S_PRESS_WAIT: begin
                if (!act) begin
                    state_d = S_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_PRESSED;
                    press_d = 1'b1;
                    rcnt_d  = '0;
                    rdone_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_PRESSED: begin
                if (!act) begin
                    state_d = S_RELEASE_WAIT;
                    cnt_d   = '0;
                end else if (rcnt_inc == (rdone_q ? R_PERIOD : R_DELAY)) begin
                    repeat_d = REPEAT_EN;
                    rcnt_d   = '0;
                    rdone_d  = 1'b1;
                end else begin
                    rcnt_d = rcnt_inc;
                end
            end
            S_RELEASE_WAIT: begin
                if (act) begin
                    state_d = S_PRESSED;
                    rcnt_d  = '0;
                    rdone_d = 1'b0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = S_IDLE;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
        pressed_d = (state_d == S_PRESSED) || (state_d == S_RELEASE_WAIT);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            rcnt_q    <= '0;
            rdone_q   <= 1'b0;
            pressed_q <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            repeat_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rcnt_q    <= rcnt_d;
            rdone_q   <= rdone_d;
            pressed_q <= pressed_d;
            press_q   <= press_d;
            release_q <= release_d;
            repeat_q  <= repeat_d;
        end
    end

    assign pressed_o       = pressed_q;
    assign press_pulse_o   = press_q;
    assign release_pulse_o = release_q;
    assign repeat_pulse_o  = repeat_q;

endmodule
